// File: rtl/NVM_pkg.sv
// Shared types for the NVM garbage-collection sequencer and its block FIFOs.
package NVM_pkg;
  localparam int BLK_W = 8;

  typedef logic [BLK_W-1:0] block_t;

  typedef enum logic [2:0] {IDLE, REQ, MOVE, ERASE, DONE} gc_state_t;
endpackage

// File: rtl/gc_blk_fifo.sv
// Block-number FIFO with synchronous clear. A push into a full FIFO is dropped
// unless a pop happens in the same cycle; a pop from an empty FIFO is a no-op.
module gc_blk_fifo
  import NVM_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  block_t                 i_din,
  output block_t                 o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  block_t        r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_C);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/gc_controller.sv
// GC sequencer: queues victims, keeps the free-block pool, and runs move -> erase -> recycle per grant.
//   IDLE  | waiting for enough victims or an allocation interrupt
//   REQ   | gc_request high, waiting for gc_start
//   MOVE  | move_flag high until the remap table reports relocation done
//   ERASE | erase timer running
//   DONE  | request_done pulse, victim recycled into the free pool
module gc_controller
  import NVM_pkg::*;
#(
  parameter int VQ_DEPTH  = 8,
  parameter int FP_DEPTH  = 8,
  parameter int GC_THRESH = 4,
  parameter int ERASE_CYC = 16
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   gc_ini,
  input  logic   gc_start,
  input  logic   invalid_flag,
  input  block_t invalid_blk,
  input  logic   active_request,
  input  logic   move_done_flag,
  input  logic   fifo_recover_en,
  input  block_t recover_blk,
  output logic   gc_request,
  output logic   gc_interrupt,
  output logic   request_done,
  output block_t erase_blk,
  output block_t active_blk,
  output logic   move_flag
);
  localparam int VQ_CW = $clog2(VQ_DEPTH) + 1;
  localparam int FP_CW = $clog2(FP_DEPTH) + 1;
  localparam int EC_W  = $clog2(ERASE_CYC + 1);
  localparam logic [VQ_CW-1:0] THRESH_C = VQ_CW'(GC_THRESH);
  localparam logic [EC_W-1:0]  ERASE_LD = EC_W'(ERASE_CYC - 1);

  gc_state_t        r_state;
  gc_state_t        w_state_nxt;
  logic [EC_W-1:0]  r_erase_cnt;
  block_t           r_erase_blk;
  block_t           r_active_blk;
  block_t           r_skid_blk;
  logic             r_skid_vld;
  logic             r_alloc_pend;
  logic             w_vq_pop;
  logic             w_vq_empty;
  logic             w_vq_full;
  logic [VQ_CW-1:0] w_vq_count;
  block_t           w_vq_dout;
  logic             w_fp_push;
  logic             w_fp_pop;
  logic             w_fp_empty;
  logic             w_fp_full;
  logic [FP_CW-1:0] w_fp_count;
  block_t           w_fp_din;
  block_t           w_fp_dout;
  logic             w_unused;

  gc_blk_fifo #(.DEPTH(VQ_DEPTH)) u_victim_q (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (gc_ini),
    .i_push  (invalid_flag),
    .i_pop   (w_vq_pop),
    .i_din   (invalid_blk),
    .o_dout  (w_vq_dout),
    .o_full  (w_vq_full),
    .o_empty (w_vq_empty),
    .o_count (w_vq_count)
  );

  gc_blk_fifo #(.DEPTH(FP_DEPTH)) u_free_pool (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (gc_ini),
    .i_push  (w_fp_push),
    .i_pop   (w_fp_pop),
    .i_din   (w_fp_din),
    .o_dout  (w_fp_dout),
    .o_full  (w_fp_full),
    .o_empty (w_fp_empty),
    .o_count (w_fp_count)
  );

  assign gc_request   = (r_state == REQ);
  assign move_flag    = (r_state == MOVE);
  assign request_done = (r_state == DONE);
  assign gc_interrupt = r_alloc_pend & w_fp_empty;
  assign erase_blk    = r_erase_blk;
  assign active_blk   = r_active_blk;
  assign w_fp_pop     = (active_request | r_alloc_pend) & ~w_fp_empty;
  assign w_unused     = ^{w_vq_full, w_fp_full, w_fp_count};

  always_comb begin
    w_state_nxt = r_state;
    w_vq_pop    = 1'b0;
    case (r_state)
      IDLE:  if ((w_vq_count >= THRESH_C) || gc_interrupt) w_state_nxt = REQ;
      REQ: begin
        if (w_vq_empty) begin
          w_state_nxt = IDLE;
        end else if (gc_start) begin
          w_vq_pop    = 1'b1;
          w_state_nxt = MOVE;
        end
      end
      MOVE:  if (move_done_flag) w_state_nxt = ERASE;
      ERASE: if (r_erase_cnt == '0) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Recycled victim wins the pool port; a coincident recover waits one cycle in the skid register.
  always_comb begin
    w_fp_push = 1'b0;
    w_fp_din  = recover_blk;
    if (r_state == DONE) begin
      w_fp_push = 1'b1;
      w_fp_din  = r_erase_blk;
    end else if (r_skid_vld) begin
      w_fp_push = 1'b1;
      w_fp_din  = r_skid_blk;
    end else if (fifo_recover_en) begin
      w_fp_push = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_erase_cnt  <= '0;
      r_erase_blk  <= '0;
      r_active_blk <= '0;
      r_skid_blk   <= '0;
      r_skid_vld   <= 1'b0;
      r_alloc_pend <= 1'b0;
    end else if (gc_ini) begin
      r_state      <= IDLE;
      r_erase_cnt  <= '0;
      r_erase_blk  <= '0;
      r_active_blk <= '0;
      r_skid_blk   <= '0;
      r_skid_vld   <= 1'b0;
      r_alloc_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_vq_pop) r_erase_blk <= w_vq_dout;
      if ((r_state == MOVE) && move_done_flag) r_erase_cnt <= ERASE_LD;
      else if ((r_state == ERASE) && (r_erase_cnt != '0)) r_erase_cnt <= r_erase_cnt - 1'b1;
      r_skid_vld <= fifo_recover_en & ((r_state == DONE) | r_skid_vld);
      if (fifo_recover_en) r_skid_blk <= recover_blk;
      if (w_fp_pop) begin
        r_active_blk <= w_fp_dout;
        r_alloc_pend <= 1'b0;
      end else if (active_request) begin
        r_alloc_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gc_controller.sv
// Directed/randomized bench for gc_controller with a queue-based reference model of both block queues.
module tb_gc_controller;
  import NVM_pkg::*;

  localparam int VQ_D   = 8;
  localparam int FP_D   = 8;
  localparam int THRESH = 4;
  localparam int ECYC   = 16;

  logic   CLK = 1'b0;
  logic   RST;
  logic   gc_ini, gc_start, invalid_flag, active_request, move_done_flag, fifo_recover_en;
  block_t invalid_blk, recover_blk;
  logic   gc_request, gc_interrupt, request_done, move_flag;
  block_t erase_blk, active_blk;

  int     total = 0;
  int     bad   = 0;
  block_t vq_m[$];
  block_t fp_m[$];
  block_t last_eb;
  bit     pend_m;

  gc_controller #(
    .VQ_DEPTH(VQ_D), .FP_DEPTH(FP_D), .GC_THRESH(THRESH), .ERASE_CYC(ECYC)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .gc_ini          (gc_ini),
    .gc_start        (gc_start),
    .invalid_flag    (invalid_flag),
    .invalid_blk     (invalid_blk),
    .active_request  (active_request),
    .move_done_flag  (move_done_flag),
    .fifo_recover_en (fifo_recover_en),
    .recover_blk     (recover_blk),
    .gc_request      (gc_request),
    .gc_interrupt    (gc_interrupt),
    .request_done    (request_done),
    .erase_blk       (erase_blk),
    .active_blk      (active_blk),
    .move_flag       (move_flag)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic block_t rnd_blk();
    return block_t'($urandom_range(1, 255));
  endfunction

  task automatic push_victim(input block_t b);
    invalid_blk  = b;
    invalid_flag = 1'b1;
    tick();
    invalid_flag = 1'b0;
    if (vq_m.size() < VQ_D) vq_m.push_back(b);
  endtask

  task automatic recover(input block_t b);
    recover_blk     = b;
    fifo_recover_en = 1'b1;
    tick();
    fifo_recover_en = 1'b0;
    if (fp_m.size() < FP_D) fp_m.push_back(b);
  endtask

  task automatic alloc(input string tag);
    active_request = 1'b1;
    tick();
    active_request = 1'b0;
    chk(tag, active_blk, fp_m.pop_front());
  endtask

  task automatic pulse_alloc_empty(input string tag);
    active_request = 1'b1;
    tick();
    active_request = 1'b0;
    pend_m = 1'b1;
    chk(tag, gc_interrupt, 1);
  endtask

  // Runs one granted pass; returns during the DONE cycle.
  task automatic run_pass(input string tag, input int move_dly);
    int n = 0;
    while (gc_request !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, gc_request, 1);
    gc_start = 1'b1;
    tick();
    gc_start = 1'b0;
    last_eb = vq_m.pop_front();
    chk({tag, "_eblk"}, erase_blk, last_eb);
    chk({tag, "_mv"}, move_flag, 1);
    repeat (move_dly) tick();
    chk({tag, "_mvhold"}, move_flag, 1);
    move_done_flag = 1'b1;
    tick();
    move_done_flag = 1'b0;
    n = 0;
    while (request_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_elen"}, n, ECYC);
    if (fp_m.size() < FP_D) fp_m.push_back(last_eb);
  endtask

  task automatic do_ini();
    gc_ini = 1'b1;
    tick();
    gc_ini = 1'b0;
    vq_m.delete();
    fp_m.delete();
    pend_m = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    gc_ini = 0; gc_start = 0; invalid_flag = 0; active_request = 0;
    move_done_flag = 0; fifo_recover_en = 0;
    invalid_blk = '0; recover_blk = '0; pend_m = 0; last_eb = '0;
    repeat (3) tick();
    chk("rst_req", gc_request, 0);
    chk("rst_int", gc_interrupt, 0);
    chk("rst_done", request_done, 0);
    chk("rst_mv", move_flag, 0);
    chk("rst_eblk", erase_blk, 0);
    chk("rst_ablk", active_blk, 0);
    RST = 1'b0;
    tick();

    // Threshold and a basic pass with victims 3,5,7,9.
    push_victim(8'd3); chk("thr_1", gc_request, 0);
    push_victim(8'd5); chk("thr_2", gc_request, 0);
    push_victim(8'd7); chk("thr_3", gc_request, 0);
    tick();            chk("thr_3b", gc_request, 0);
    push_victim(8'd9); chk("thr_4lag", gc_request, 0);
    tick();            chk("thr_4", gc_request, 1);
    run_pass("p0", 3);
    tick();
    chk("done_1cyc", request_done, 0);
    chk("below_thr", gc_request, 0);
    alloc("pool_holds3");
    chk("no_int", gc_interrupt, 0);

    // gc_ini clears everything; allocation from an empty pool raises the interrupt.
    do_ini();
    chk("ini_eblk", erase_blk, 0);
    chk("ini_ablk", active_blk, 0);
    pulse_alloc_empty("int_set");
    tick();
    chk("int_hold", gc_interrupt, 1);
    recover(8'd12);
    chk("int_clr", gc_interrupt, 0);
    tick();
    chk("serve12", active_blk, fp_m.pop_front());
    pend_m = 1'b0;
    repeat (3) tick();
    chk("idle_after_int", gc_request, 0);

    // Random pool fill past capacity, drain in order, then one more request on empty.
    for (int i = 0; i < FP_D + 1; i++) recover(rnd_blk());
    for (int i = 0; i < FP_D; i++) alloc("pool_order");
    pulse_alloc_empty("pool_empty_int");
    recover(rnd_blk());
    chk("pool_int_clr", gc_interrupt, 0);
    tick();
    chk("pool_serve", active_blk, fp_m.pop_front());
    pend_m = 1'b0;

    // Victim queue overflow: nine pushes, eight passes, no ninth block.
    do_ini();
    for (int i = 0; i < VQ_D + 1; i++) push_victim(rnd_blk());
    for (int p = 0; p < VQ_D; p++) begin
      if (vq_m.size() < THRESH) begin
        while (fp_m.size() > 0) alloc("drain");
        pulse_alloc_empty("drain_int");
      end
      run_pass("ovf", int'($urandom_range(0, 3)));
      tick();
      if (pend_m) begin
        tick();
        chk("ovf_serve", active_blk, fp_m.pop_front());
        pend_m = 1'b0;
      end
    end
    while (fp_m.size() > 0) alloc("drain2");
    gc_start = 1'b1;
    pulse_alloc_empty("no9_int");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no9_done", request_done, 0);
      chk("no9_mv", move_flag, 0);
    end
    gc_start = 1'b0;
    chk("no9_eblk", erase_blk, last_eb);
    recover(rnd_blk());
    tick();
    chk("no9_serve", active_blk, fp_m.pop_front());
    pend_m = 1'b0;

    // Recycle and recover in the same DONE cycle: recycle lands first.
    do_ini();
    for (int i = 0; i < THRESH; i++) push_victim(rnd_blk());
    run_pass("dual", 1);
    recover_blk     = rnd_blk();
    fifo_recover_en = 1'b1;
    tick();
    fifo_recover_en = 1'b0;
    if (fp_m.size() < FP_D) fp_m.push_back(recover_blk);
    alloc("dual_first");
    alloc("dual_second");

    // Asynchronous reset in the middle of ERASE.
    recover(rnd_blk());
    push_victim(rnd_blk());
    begin
      int n = 0;
      while (gc_request !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("mid_req", gc_request, 1);
    end
    gc_start = 1'b1;
    tick();
    gc_start = 1'b0;
    chk("mid_eblk", erase_blk, vq_m.pop_front());
    move_done_flag = 1'b1;
    tick();
    move_done_flag = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    #1;
    chk("arst_req", gc_request, 0);
    chk("arst_int", gc_interrupt, 0);
    chk("arst_done", request_done, 0);
    chk("arst_mv", move_flag, 0);
    chk("arst_eblk", erase_blk, 0);
    chk("arst_ablk", active_blk, 0);
    repeat (2) tick();
    RST = 1'b0;
    vq_m.delete();
    fp_m.delete();
    pend_m = 1'b0;
    tick();
    for (int i = 0; i < THRESH - 1; i++) push_victim(rnd_blk());
    repeat (2) tick();
    chk("arst_vq_empty", gc_request, 0);
    pulse_alloc_empty("arst_fp_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
